turn_ctl: RTL

Turn scheduler for the two-player throwing game. It grants the throw engine to one player at a time and draws a new wind value for every turn. It launches the throw, waits for the landing report, scores hits against the opponent's position and tracks hit points until one player reaches zero. It sits between the player input logic and the throw trajectory engine, and drives the HUD (HP, wind, turn and winner indicators).

---
 rtl/turn_pkg.sv | 34 +++
 rtl/wind_lfsr.sv | 46 ++++
 rtl/turn_ctl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/turn_pkg.sv
// rtl/turn_pkg.sv - shared types, constants and scoring helper for the turn scheduler
package turn_pkg;

    localparam int COORD_W = 12;
    localparam int HP_W    = 4;
    localparam int WIND_W  = 7;

    localparam logic [15:0]       LFSR_SEED = 16'hACE1;
    localparam logic [WIND_W-1:0] WIND_CALM = 7'd50;

    typedef enum logic [2:0] {
        READY  = 3'd0,
        LAUNCH = 3'd1,
        FLIGHT = 3'd2,
        SCORE  = 3'd3,
        SWITCH = 3'd4,
        OVER   = 3'd5
    } state_t;

    // One extra bit of headroom makes the landing offset a proper signed value,
    // so a landing left of the target never wraps into a large positive number.
    function automatic logic in_window(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] c,
        input logic [COORD_W-1:0] half
    );
        logic signed [COORD_W:0] d;
        logic signed [COORD_W:0] h;
        d = $signed({1'b0, x}) - $signed({1'b0, c});
        h = $signed({1'b0, half});
        return (d >= -h) && (d <= h);
    endfunction

endpackage

// File: rtl/wind_lfsr.sv
// rtl/wind_lfsr.sv - free-running 16-bit wind LFSR with 0..100 wind register
module wind_lfsr
    import turn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              calm,
    output logic [WIND_W-1:0] wind
);

    logic [15:0]       r_lfsr;
    logic [WIND_W-1:0] r_wind;
    logic              w_fb;
    logic [WIND_W-1:0] w_raw;
    logic [WIND_W-1:0] w_map;

    // Taps 16/14/13/11 counted from the output end of a right-shifting register.
    assign w_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_raw = r_lfsr[WIND_W-1:0];
    // 101..127 folds back onto 1..27 so every draw lands in 0..100.
    assign w_map = (w_raw <= 7'd100) ? w_raw : (w_raw - 7'd100);

    // LFSR steps every cycle so wind depends on how long each turn took.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    // Wind register: calm on reset or restart, fresh draw on turn change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wind <= WIND_CALM;
        end else if (calm) begin
            r_wind <= WIND_CALM;
        end else if (load) begin
            r_wind <= w_map;
        end
    end

    assign wind = r_wind;

endmodule

// File: rtl/turn_ctl.sv
// rtl/turn_ctl.sv - two-player turn scheduler: launch, timeout, scoring and hit points
module turn_ctl
    import turn_pkg::*;
#(
    parameter logic [COORD_W-1:0] P0_X        = 12'd100,
    parameter logic [COORD_W-1:0] P1_X        = 12'd900,
    parameter logic [COORD_W-1:0] HIT_HALF    = 12'd24,
    parameter logic [HP_W-1:0]    MAX_HP      = 4'd5,
    parameter logic [31:0]        TIMEOUT_CYC = 32'd100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         fire,
    input  logic               new_game,
    input  logic               land_valid,
    input  logic [COORD_W-1:0] land_x,
    output logic               throw_start,
    output logic               throw_dir,
    output logic [WIND_W-1:0]  wind,
    output logic               active_player,
    output logic [HP_W-1:0]    hp0,
    output logic [HP_W-1:0]    hp1,
    output logic               hit,
    output logic               miss,
    output logic               game_over,
    output logic               winner
);

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_tmo_cnt;
    logic              r_active;
    logic              r_winner;
    logic              r_throw_start;
    logic              r_hit;
    logic              r_miss;
    logic              r_game_over;
    logic              r_score_hit;
    logic [HP_W-1:0]   r_hp0;
    logic [HP_W-1:0]   r_hp1;

    logic [COORD_W-1:0] w_target;
    logic               w_in_win;
    logic               w_tmo;
    logic               w_land_hit;
    logic               w_score_edge;
    logic [HP_W-1:0]    w_opp_hp;
    logic [HP_W-1:0]    w_opp_hp_dec;
    logic               w_wind_load;
    logic               w_wind_calm;

    // Player 0 aims at player 1's target and vice versa.
    assign w_target     = r_active ? P0_X : P1_X;
    assign w_in_win     = in_window(land_x, w_target, HIT_HALF);
    assign w_tmo        = (r_tmo_cnt == (TIMEOUT_CYC - 32'd1));
    // A landing report in the timeout cycle still counts as a real landing.
    assign w_land_hit   = land_valid && w_in_win;
    assign w_score_edge = (r_state == FLIGHT) && (land_valid || w_tmo);
    assign w_opp_hp     = r_active ? r_hp0 : r_hp1;
    assign w_opp_hp_dec = (w_opp_hp == '0) ? '0 : (w_opp_hp - 4'd1);
    assign w_wind_load  = (r_state == SWITCH);
    assign w_wind_calm  = (r_state == OVER) && new_game;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= READY;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; stray inputs in other states simply hold the state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            READY:   if (fire[r_active]) w_next = LAUNCH;
            LAUNCH:  w_next = FLIGHT;
            FLIGHT:  if (land_valid || w_tmo) w_next = SCORE;
            SCORE:   w_next = (r_score_hit && (w_opp_hp_dec == '0)) ? OVER : SWITCH;
            SWITCH:  w_next = READY;
            OVER:    if (new_game) w_next = READY;
            default: w_next = READY;
        endcase
    end

    // Flight timer: zeroed at launch, counts each FLIGHT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == LAUNCH) begin
            r_tmo_cnt <= '0;
        end else if (r_state == FLIGHT) begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end
    end

    // Registered pulses and status, decided on the edge entering the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_throw_start <= 1'b0;
            r_hit         <= 1'b0;
            r_miss        <= 1'b0;
            r_game_over   <= 1'b0;
            r_score_hit   <= 1'b0;
        end else begin
            r_throw_start <= (r_state == READY) && (w_next == LAUNCH);
            r_hit         <= w_score_edge && w_land_hit;
            r_miss        <= w_score_edge && !w_land_hit;
            r_game_over   <= (w_next == OVER);
            if (r_state == FLIGHT) begin
                r_score_hit <= w_land_hit;
            end
        end
    end

    // Hit points, turn ownership and winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hp0    <= MAX_HP;
            r_hp1    <= MAX_HP;
            r_active <= 1'b0;
            r_winner <= 1'b0;
        end else begin
            case (r_state)
                SCORE: begin
                    if (r_score_hit) begin
                        if (r_active) begin
                            r_hp0 <= w_opp_hp_dec;
                        end else begin
                            r_hp1 <= w_opp_hp_dec;
                        end
                        if (w_opp_hp_dec == '0) begin
                            r_winner <= r_active;
                        end
                    end
                end
                SWITCH: r_active <= ~r_active;
                OVER: begin
                    if (new_game) begin
                        r_hp0    <= MAX_HP;
                        r_hp1    <= MAX_HP;
                        r_active <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    wind_lfsr u_wind (
        .clk  (clk),
        .rst  (rst),
        .load (w_wind_load),
        .calm (w_wind_calm),
        .wind (wind)
    );

    assign throw_start   = r_throw_start;
    assign throw_dir     = r_active;
    assign active_player = r_active;
    assign hp0           = r_hp0;
    assign hp1           = r_hp1;
    assign hit           = r_hit;
    assign miss          = r_miss;
    assign game_over     = r_game_over;
    assign winner        = r_winner;

endmodule
